muldiv_unit: RTL and testbench

- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Its read result (mfhi/mflo) travels E->M->W in the muldiv result field and is written back in W.
- Models a multi-cycle datapath: exposes busy so the hazard unit can stall later HI/LO users.
- Arithmetic is computed at launch; results are committed to HI/LO only after the programmed latency.

---
 rtl/muldiv_if.sv | 23 ++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
// The master is the pipeline side; the slave is the muldiv unit itself.
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] res;

  modport master (
    output start, op, rs_val, rt_val, mf_sel,
    input  busy, hi, lo, res
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_sel,
    output busy, hi, lo, res
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at launch, parked in shadow registers, and committed after a fixed latency.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        shd_hi_q, shd_hi_d;
  logic [31:0]        shd_lo_q, shd_lo_d;
  logic               shd_dz_q, shd_dz_d;

  logic signed [63:0] a_s, b_s, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] dvsr;
  logic signed [31:0] rs_s, dvsr_s;
  logic        [31:0] quo_s, rem_s, quo_u, rem_u;
  logic               div_zero, div_ovf;

  always_comb begin
    a_s      = {{32{bus.rs_val[31]}}, bus.rs_val};
    b_s      = {{32{bus.rt_val[31]}}, bus.rt_val};
    prod_s   = a_s * b_s;
    prod_u   = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    div_zero = (bus.rt_val == 32'd0);
    div_ovf  = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);
    // Substitute safe divisors so the dividers never see /0 or the signed overflow case.
    dvsr     = (div_zero || div_ovf) ? 32'd1 : bus.rt_val;
    rs_s     = $signed(bus.rs_val);
    dvsr_s   = $signed(dvsr);
    quo_u    = bus.rs_val / dvsr;
    rem_u    = bus.rs_val % dvsr;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = rs_s / dvsr_s;
      rem_s = rs_s % dvsr_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shd_hi_d = shd_hi_q;
    shd_lo_d = shd_lo_q;
    shd_dz_d = shd_dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT: begin
              {shd_hi_d, shd_lo_d} = prod_s;
              shd_dz_d = 1'b0;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_MULTU: begin
              {shd_hi_d, shd_lo_d} = prod_u;
              shd_dz_d = 1'b0;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = RUN;
            end
            OP_DIV: begin
              shd_hi_d = rem_s;
              shd_lo_d = quo_s;
              shd_dz_d = div_zero;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_DIVU: begin
              shd_hi_d = rem_u;
              shd_lo_d = quo_u;
              shd_dz_d = div_zero;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last busy cycle: commit unless the launch was a divide by zero.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!shd_dz_q) begin
            hi_d = shd_hi_q;
            lo_d = shd_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      shd_hi_q <= '0;
      shd_lo_q <= '0;
      shd_dz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shd_hi_q <= shd_hi_d;
      shd_lo_q <= shd_lo_d;
      shd_dz_q <= shd_dz_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.res  = bus.mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of launches plus hand-written
// sequences for MTHI/MTLO, ops issued while busy, and reset during a divide.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  muldiv_if bus();

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one start edge, then scrambles operands to prove they were sampled at launch.
  task automatic launch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    next_cycle();
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.rs_val = 32'hA5A5_A5A5;
    bus.rt_val = 32'h5A5A_5A5A;
  endtask

  task automatic count_busy(input string name, input logic [31:0] old_hi,
                            input logic [31:0] old_lo, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      if (n == 0) begin
        chk({name, " hi held while busy"}, bus.hi, old_hi);
        chk({name, " lo held while busy"}, bus.lo, old_lo);
      end
      n++;
      next_cycle();
    end
  endtask

  initial begin
    int n;
    logic [31:0] old_hi, old_lo;

    vecs[0] = '{"mult -2*3",      3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu ffff*2",   3'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div -7/2",       3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu 7/0",       3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{"div ovf",        3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{"divu 100/7",     3'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
    vecs[6] = '{"div 7/-2",       3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[7] = '{"div -5/0",       3'd3, 32'hFFFF_FFFB, 32'd0,         32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[8] = '{"multu 2^31sq",   3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[9] = '{"mult -1*-1",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5};

    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.mf_sel = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset res lo", bus.res, 32'd0);
    bus.mf_sel = 1'b1;
    #1;
    chk("reset res hi", bus.res, 32'd0);

    // NONE and reserved ops must leave HI/LO alone.
    launch(3'd7, 32'h1111_1111, 32'h2222_2222);
    chk("op7 busy", {31'd0, bus.busy}, 32'd0);
    chk("op7 hi", bus.hi, 32'd0);

    for (int i = 0; i < 10; i++) begin
      old_hi = bus.hi;
      old_lo = bus.lo;
      launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
      count_busy(vecs[i].name, old_hi, old_lo, n);
      chk({vecs[i].name, " busy cycles"}, 32'(n), 32'(vecs[i].exp_cyc));
      chk({vecs[i].name, " hi"}, bus.hi, vecs[i].exp_hi);
      chk({vecs[i].name, " lo"}, bus.lo, vecs[i].exp_lo);
      bus.mf_sel = 1'b1;
      #1;
      chk({vecs[i].name, " res hi"}, bus.res, vecs[i].exp_hi);
      bus.mf_sel = 1'b0;
      #1;
      chk({vecs[i].name, " res lo"}, bus.res, vecs[i].exp_lo);
    end

    // Second MULT and an MTHI issued mid-flight are ignored.
    launch(3'd1, 32'd6, 32'd7);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      if (n == 2) begin
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'h1000; bus.rt_val = 32'h1000;
      end else if (n == 3) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.rs_val = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0; bus.op = 3'd0;
      end
      n++;
      next_cycle();
    end
    bus.start = 1'b0;
    bus.op    = 3'd0;
    chk("busy-ignore cycles", 32'(n), 32'd5);
    chk("busy-ignore hi", bus.hi, 32'd0);
    chk("busy-ignore lo", bus.lo, 32'd42);
    next_cycle();
    chk("busy-ignore no relaunch", {31'd0, bus.busy}, 32'd0);

    launch(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi hi", bus.hi, 32'h1234_5678);
    chk("mthi lo kept", bus.lo, 32'd42);
    chk("mthi busy", {31'd0, bus.busy}, 32'd0);
    launch(3'd6, 32'hCAFE_F00D, 32'd0);
    chk("mtlo lo", bus.lo, 32'hCAFE_F00D);
    chk("mtlo hi kept", bus.hi, 32'h1234_5678);

    // Reset during the third busy cycle of a DIV aborts it without a commit.
    launch(3'd3, 32'd100, 32'd7);
    n = 0;
    while (bus.busy === 1'b1 && n < 3) begin
      n++;
      if (n < 3) next_cycle();
    end
    chk("abort reached busy", 32'(n), 32'd3);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) n++;
    end
    chk("abort no late commit", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
